// File: rtl/nn_mac_engine.sv
// nn_mac_engine: fixed-point dot-product neuron core.
// It performs one signed multiply-accumulate per clock over the buffered
// activation/weight pairs, starting from a sign-extended bias. The sum is then
// arithmetically shifted, saturated to DW bits and optionally rectified.
//
// Ports:
//   wb_clk_i, wb_rst_i  clock and synchronous active-high reset
//   wr_en/wr_addr       write wr_x/wr_w into one buffer slot (ignored while busy)
//   wr_x, wr_w          signed activation / weight
//   len, bias, relu_en  run parameters, sampled when start is accepted
//   start               begin a computation (honoured only when idle)
//   busy                high from the edge after start until the result is written
//   done                one-cycle pulse when result is valid
//   result              saturated (and optionally rectified) neuron output
//   acc_o               raw acc + bias before the shift
//   overflow            saturation occurred in the last computation
module nn_mac_engine #(
  parameter int DW    = 8,
  parameter int N_MAX = 16,
  parameter int SHIFT = 4,
  parameter int ACC_W = 2*DW + $clog2(N_MAX) + 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wr_en,
  input  logic [$clog2(N_MAX)-1:0]  wr_addr,
  input  logic [DW-1:0]             wr_x,
  input  logic [DW-1:0]             wr_w,
  input  logic [$clog2(N_MAX):0]    len,
  input  logic [15:0]               bias,
  input  logic                      relu_en,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [DW-1:0]             result,
  output logic [ACC_W-1:0]          acc_o,
  output logic                      overflow
);

  localparam int AW = $clog2(N_MAX);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(N_MAX);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, POST} state_t;

  state_t state, state_nxt;

  logic signed [DW-1:0]    x_mem [N_MAX];
  logic signed [DW-1:0]    w_mem [N_MAX];
  logic [AW:0]             len_q;
  logic [AW:0]             idx;
  logic                    relu_q;
  logic signed [ACC_W-1:0] acc;

  // Snapshot of the slot overwritten by a write issued together with start.
  // The write lands in the buffer, but the run must still see the old pair,
  // so the operand mux substitutes the snapshot for that one slot.
  logic                    sh_valid;
  logic [AW-1:0]           sh_addr;
  logic signed [DW-1:0]    sh_x;
  logic signed [DW-1:0]    sh_w;

  logic [AW:0]             len_c;
  logic signed [DW-1:0]    x_op;
  logic signed [DW-1:0]    w_op;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] sat;
  logic                    ovf_c;
  logic [DW-1:0]           res_c;

  assign len_c    = (len > LEN_MAX) ? LEN_MAX : len;
  assign bias_ext = {{(ACC_W-16){bias[15]}}, bias};

  always_comb begin
    x_op = x_mem[idx[AW-1:0]];
    w_op = w_mem[idx[AW-1:0]];
    if (sh_valid && (sh_addr == idx[AW-1:0])) begin
      x_op = sh_x;
      w_op = sh_w;
    end
  end

  assign prod     = x_op * w_op;
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

  always_comb begin
    shifted = acc >>> SHIFT;
    sat     = shifted;
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN;
    end
    ovf_c = (shifted != sat);
    res_c = (relu_q && sat[ACC_W-1]) ? '0 : sat[DW-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len_c != '0) ? RUN : POST;
      RUN:  if (idx == (len_q - 1'b1)) state_nxt = POST;
      POST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < N_MAX; i++) begin
        x_mem[i] <= '0;
        w_mem[i] <= '0;
      end
      len_q    <= '0;
      idx      <= '0;
      relu_q   <= 1'b0;
      acc      <= '0;
      sh_valid <= 1'b0;
      sh_addr  <= '0;
      sh_x     <= '0;
      sh_w     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      acc_o    <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            x_mem[wr_addr] <= wr_x;
            w_mem[wr_addr] <= wr_w;
          end
          if (start) begin
            len_q    <= len_c;
            relu_q   <= relu_en;
            acc      <= bias_ext;
            idx      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            sh_valid <= wr_en;
            sh_addr  <= wr_addr;
            sh_x     <= x_mem[wr_addr];
            sh_w     <= w_mem[wr_addr];
          end
        end
        RUN: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
        end
        POST: begin
          overflow <= ovf_c;
          result   <= res_c;
          acc_o    <= acc;
          done     <= 1'b1;
          busy     <= 1'b0;
          sh_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mac_engine.sv
// Self-checking bench for nn_mac_engine: a behavioural model predicts busy,
// done, result, acc_o and overflow every cycle; directed cases pin the model
// with hand-computed values, then randomized runs exercise the rest.
module tb_nn_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_x = '0;
  logic [7:0]  wr_w = '0;
  logic [4:0]  len = '0;
  logic [15:0] bias = '0;
  logic        relu_en = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic [20:0] acc_o;
  logic        overflow;

  nn_mac_engine #(.DW(8), .N_MAX(16), .SHIFT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_w(wr_w), .len(len), .bias(bias), .relu_en(relu_en),
    .start(start), .busy(busy), .done(done), .result(result),
    .acc_o(acc_o), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  function automatic void chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int     mx [16];
  int     mw [16];
  bit     m_busy, m_done, m_ovf;
  int     m_res, m_cnt;
  longint m_acc;
  int     p_res;
  longint p_acc;
  bit     p_ovf;

  task automatic predict(input int lq, input int b, input bit r);
    longint a, s, sat;
    a = b;
    for (int k = 0; k < lq; k++) a += longint'(mx[k]) * longint'(mw[k]);
    s = a >>> 4;
    sat = (s > 127) ? 127 : ((s < -128) ? -128 : s);
    p_acc = a;
    p_ovf = (s != sat);
    p_res = (r && sat < 0) ? 0 : int'(sat);
  endtask

  always @(posedge clk) begin
    bit was_busy;
    int lq;
    was_busy = m_busy;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin mx[k] = 0; mw[k] = 0; end
      m_busy = 0; m_done = 0; m_ovf = 0; m_res = 0; m_acc = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_done = 1;
          m_res = p_res; m_acc = p_acc; m_ovf = p_ovf;
        end
      end else if (start) begin
        lq = (int'(len) > 16) ? 16 : int'(len);
        predict(lq, int'($signed(bias)), relu_en);
        m_ovf = 0; m_busy = 1; m_cnt = lq + 1;
      end
      if (wr_en && !was_busy) begin
        mx[wr_addr] = int'($signed(wr_x));
        mw[wr_addr] = int'($signed(wr_w));
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("result", $signed(result), m_res);
      chk("acc_o", $signed(acc_o), m_acc);
      chk("overflow", overflow, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input int x, input int w);
    logic [31:0] xv, wv;
    xv = x; wv = w;
    wr_en = 1'b1; wr_addr = a[3:0]; wr_x = xv[7:0]; wr_w = wv[7:0];
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill(input int x, input int w);
    for (int k = 0; k < 16; k++) wr(k, x, w);
  endtask

  // Returns the number of negedges until done is seen (1 = cycle after E0).
  task automatic wait_done_neg(output int n);
    bit found;
    n = 0; found = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = i; found = 1; break; end
    end
    if (!found) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
    end
  endtask

  task automatic run(input int l, input int b, input bit r, input bit sim_wr,
                     input int sa, input int sx, input int sw, input bit poke,
                     output int lat);
    logic [31:0] lv, bv, xv, wv;
    lv = l; bv = b; xv = sx; wv = sw;
    len = lv[4:0]; bias = bv[15:0]; relu_en = r; start = 1'b1;
    if (sim_wr) begin
      wr_en = 1'b1; wr_addr = sa[3:0]; wr_x = xv[7:0]; wr_w = wv[7:0];
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    if (poke) begin
      start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_x = 8'd99; wr_w = 8'd99;
      tick();
      start = 1'b0; wr_en = 1'b0;
    end
    wait_done_neg(lat);
    if (poke) lat = lat + 1;
    tick();
  endtask

  initial begin
    int lat;
    int lat2;
    @(posedge clk); #1;
    armed = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_result", $signed(result), 0);
    chk("reset_busy", busy, 0);

    // basic dot product
    wr(0, 1, 5); wr(1, 2, 6); wr(2, 3, 7); wr(3, 4, 8);
    run(4, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("basic_model_acc", m_acc, 70);
    chk("basic_acc_o", $signed(acc_o), 70);
    chk("basic_result", $signed(result), 4);
    chk("basic_overflow", overflow, 0);
    chk("basic_latency", lat, 6);

    // saturation
    fill(127, 127);
    run(16, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("satp_acc_o", $signed(acc_o), 258064);
    chk("satp_result", $signed(result), 127);
    chk("satp_overflow", overflow, 1);
    fill(-128, 127);
    run(16, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("satn_model_acc", m_acc, -260096);
    chk("satn_acc_o", $signed(acc_o), -260096);
    chk("satn_result", $signed(result), -128);
    chk("satn_overflow", overflow, 1);

    // rounding toward -inf and relu
    wr(0, -10, 10);
    run(1, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("round_result", $signed(result), -7);
    run(1, 0, 1, 0, 0, 0, 0, 0, lat);
    chk("relu_result", $signed(result), 0);
    chk("relu_overflow", overflow, 0);

    // bias only, length clamp
    run(0, 80, 0, 0, 0, 0, 0, 0, lat);
    chk("bias_result", $signed(result), 5);
    chk("bias_latency", lat, 2);
    fill(1, 1);
    run(20, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("clamp_acc_o", $signed(acc_o), 16);
    chk("clamp_result", $signed(result), 1);
    chk("clamp_latency", lat, 18);

    // start/wr_en during RUN are ignored
    wr(0, 2, 3);
    run(16, 0, 0, 0, 0, 0, 0, 1, lat);
    chk("poke_acc_o", $signed(acc_o), 21);
    run(16, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("poke_rerun_acc_o", $signed(acc_o), 21);

    // back-to-back start in the done cycle
    len = 5'd4; bias = 16'd0; relu_en = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    wait_done_neg(lat);
    len = 5'd1; bias = 16'd32; start = 1'b1;
    tick(); start = 1'b0;
    wait_done_neg(lat2);
    tick();
    chk("b2b_latency", lat2, 3);
    chk("b2b_result", $signed(result), 2);

    // write together with start: run uses the old slot value
    run(1, 0, 0, 1, 0, 5, 5, 0, lat);
    chk("simwr_acc_o", $signed(acc_o), 6);
    run(1, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("simwr_rerun_acc_o", $signed(acc_o), 25);

    // reset mid-run
    fill(3, 3);
    len = 5'd8; bias = 16'd0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("rst_busy", busy, 0);
    chk("rst_result", $signed(result), 0);
    run(8, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("rst_rerun_result", $signed(result), 0);
    chk("rst_rerun_latency", lat, 10);

    // randomized runs
    for (int it = 0; it < 80; it++) begin
      int nw, bv;
      nw = $urandom_range(0, 6);
      for (int k = 0; k < nw; k++) wr($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
      bv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 400)) - 200;
      run($urandom_range(0, 20), bv, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
          $urandom_range(0, 255), $urandom_range(0, 255),
          ($urandom_range(0, 3) == 0), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
